// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, state encoding and mode constants for the arbiter
package arb_pkg;
  localparam int N = 8;
  localparam int IDW = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational 8-to-3 priority encoder, highest index wins
module prio_enc8 (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       valid
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) if (in[i]) idx = 3'(i);
  end
  assign valid = |in;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: eight-way fixed-priority / round-robin arbiter with registered grant and hold limit
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_v,
  output logic           tmo
);
  localparam int CW = MAX_HOLD < 2 ? 1 : $clog2(MAX_HOLD + 1);
  state_t         state;
  logic [IDW-1:0] ptr, base, enc, win;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   rot;
  logic           any, hit, rel;
  assign base = mode == MODE_RR ? ptr : '0;
  assign rot  = N'({req, req} >> base);
  prio_enc8 u_enc (.in(rot), .idx(enc), .valid(any));
  assign win = enc + base;
  assign hit = MAX_HOLD != 0 && cnt == CW'(MAX_HOLD);
  assign rel = done || !req[gnt_id] || !en || hit;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      gnt_v  <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      tmo <= 1'b0;
      if (state == IDLE) begin
        if (en && any) begin
          state  <= GRANT;
          gnt    <= N'(1) << win;
          gnt_id <= win;
          gnt_v  <= 1'b1;
          cnt    <= CW'(1);
          ptr    <= win;
        end
      end else if (rel) begin
        state  <= IDLE;
        gnt    <= '0;
        gnt_id <= '0;
        gnt_v  <= 1'b0;
        tmo    <= hit && !done;
      end else if (MAX_HOLD != 0) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Sequential arbiter sharing one resource among eight requesters, built around the team's 8-to-3 priority encoder. It selects a winner under fixed priority (highest index wins) or round-robin, and issues a registered one-hot grant plus a 3-bit grant index and valid. It holds the grant until the owner releases it, drops its request, or exceeds a hold limit. It sits in front of any shared datapath resource (bus port, memory bank, encoder lane) whose users post requests as an 8-bit vector.

## Interface
- N, 8, number of requesters; fixed at 8 in this revision, because the encoder is 8-to-3
- IDW, 3, width of the grant index (log2 N)
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the limit
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous, active-low reset
- en  input  1  arbitration enable; when low, no new grant is issued and any held grant is released
- mode  input  1  0 = fixed priority (req[7] highest), 1 = round-robin
- req  input  8  request vector, one bit per requester, level-held while wanting the resource
- done  input  1  owner release pulse, sampled only while a grant is active
- gnt  output  8  one-hot grant, registered
- gnt_id  output  3  index of the granted requester, registered
- gnt_v  output  1  grant valid, registered; equals |gnt
- tmo  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD

## Operation
- Reset (rst_n low at a clk edge):
  - gnt=0, gnt_id=0, gnt_v=0, tmo=0.
  - State IDLE, round-robin pointer ptr=0, hold counter=0.
  - Reset overrides everything, including mid-grant.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If en=1 and req!=0, compute the winner w. Then gnt=1<<w, gnt_id=w, gnt_v=1, hold counter=1, ptr=w, and go to GRANT.
  - Otherwise all grant outputs stay 0.
- Fixed priority (mode=0): the highest set bit of req wins, with the same ordering as the priority encoder.
- Round-robin (mode=1):
  - Search order is ptr-1, ptr-2, …, ptr+1, ptr, descending with mod-8 wrap. The last winner therefore has the lowest priority.
  - With ptr=0 the order is 7..0, identical to fixed priority.
- ptr updates on every grant, in both modes. mode may change at any time and takes effect at the next arbitration.
- GRANT: release, meaning return to IDLE and clear gnt, gnt_id and gnt_v, when any of the following holds:
  - done=1
  - req[gnt_id]=0 (the owner withdrew)
  - en=0
  - MAX_HOLD!=0 and hold counter==MAX_HOLD; in this case tmo=1 for that one cycle only
- If none holds, outputs are held and the hold counter increments, saturating at MAX_HOLD.
- Simultaneous events: any release condition together with a new request still releases. The new request is arbitrated in the following IDLE cycle, so there is no grant-to-grant handoff in the same edge.
- Timeout precedence: when done and the timeout coincide, tmo=0 (clean release wins).
- Hold counter width: enough bits for MAX_HOLD (minimum 1). Comparison is unsigned.
- req bits other than the owner's are ignored during GRANT.

## Timing
- Request to grant: 1 cycle. req sampled at edge k in IDLE gives gnt valid after edge k.
- Release: the condition sampled at edge m gives gnt=0 after edge m. The earliest next grant is after edge m+1.
- Minimum gap between grants: 1 idle cycle. A continuously requesting single requester gets a grant every 2 cycles at most.
- Maximum grant length: MAX_HOLD cycles of gnt_v=1, followed by exactly one tmo cycle coinciding with gnt_v=0.
- No combinational path from req, done or en to the outputs; all outputs are registered.

## Structure
- Shared package `arb_pkg`:
  - N and IDW localparams
  - state enum {IDLE, GRANT}
  - MODE_FIXED=0, MODE_RR=1 constants
- Sub-module `prio_enc8`: combinational 8-to-3, highest index wins, with a valid output.
  - rr_arbiter rotates req right by ptr, encodes the result, then adds ptr back mod 8.
  - Fixed mode feeds req unrotated (equivalent to ptr=0).
- Top level holds the FSM, ptr, hold counter and output registers. Expected size is about 150–200 lines total.

## Test plan
- Reset mid-grant: grant requester 3, then hold rst_n low for 1 cycle → gnt=0, gnt_v=0, tmo=0 and ptr=0. Next req=8'h08 gives gnt=8'h08 one cycle after.
- Fixed priority: mode=0, req=8'b0101_0010 with en=1 → after 1 edge gnt=8'h40, gnt_id=6. Pulse done → gnt=0. Next grant again goes to 6 while req is unchanged.
- Round-robin fairness: mode=1, req=8'hFF held, done pulsed each grant → gnt_id sequence 7,6,5,4,3,2,1,0,7, each grant separated by one idle cycle.
- Timeout: MAX_HOLD=4, req=8'h01 held, no done → gnt_v=1 for exactly 4 cycles, then gnt_v=0 with tmo=1 for 1 cycle. Re-grant follows after one more edge.
- Owner withdrawal and enable: granted to requester 2, drop req[2] → release next edge, tmo=0. Separately, drop en mid-grant → release. With en=0 and req=8'hFF, gnt stays 0.
- Coincident done and timeout: MAX_HOLD=3 and done asserted on the third grant cycle → release with tmo=0. Wrap-around check: ptr=0, req=8'h81 → gnt_id=7, then after release gnt_id=0.
